// File: rtl/n5_uart_tx.sv
// n5_uart_tx: 8N1 UART transmitter fed from a small circular byte FIFO.
// Frames go out LSB first: start bit low, 8 data bits, then 1 or 2 high stop bits.
// Each bit lasts (div+1) clocks.
module n5_uart_tx #(
    parameter int DEPTH = 8,
    parameter int DIV_W = 16
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     en,
    input  logic [DIV_W-1:0]         div,
    input  logic                     stop2,
    input  logic [7:0]               wdata,
    input  logic                     wr,
    input  logic                     clr_ovf,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    output logic                     busy,
    output logic                     done,
    output logic                     tx
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // FIFO storage and bookkeeping
    logic [7:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      level_reg, level_next;
    logic             ovf_reg;
    logic             push_ok;
    logic             pop;

    // Frame engine state
    state_t           state_reg, state_next;
    logic [DIV_W-1:0] timer_reg, timer_next;
    logic [DIV_W-1:0] div_lat_reg, div_lat_next;
    logic             s2_lat_reg, s2_lat_next;
    logic             second_reg, second_next;
    logic [2:0]       bit_cnt_reg, bit_cnt_next;
    logic [7:0]       shift_reg, shift_next;
    logic             tx_reg, tx_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             start_now;
    logic             can_start;

    // full is judged before this cycle's pop, so a push while full is always dropped
    assign full      = (level_reg == FULL_LEVEL);
    assign empty     = (level_reg == '0);
    assign push_ok   = wr && !full;
    assign can_start = en && !empty;

    // Occupancy update from push/pop pair
    always_comb begin
        level_next = level_reg;
        case ({push_ok, pop})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
    end

    // FIFO storage write port; contents need no reset since pointers define validity
    always_ff @(posedge wb_clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // FIFO pointers, level and sticky overflow flag (a drop beats a clear)
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
            level_reg <= level_next;
            if (wr && full)   ovf_reg <= 1'b1;
            else if (clr_ovf) ovf_reg <= 1'b0;
        end
    end

    // Frame engine state register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg   <= S_IDLE;
            timer_reg   <= '0;
            div_lat_reg <= '0;
            s2_lat_reg  <= 1'b0;
            second_reg  <= 1'b0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            div_lat_reg <= div_lat_next;
            s2_lat_reg  <= s2_lat_next;
            second_reg  <= second_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            tx_reg      <= tx_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    // Frame engine next-state: bit timing, shifting, stop bits and frame chaining
    always_comb begin
        state_next   = state_reg;
        timer_next   = timer_reg;
        div_lat_next = div_lat_reg;
        s2_lat_next  = s2_lat_reg;
        second_next  = second_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        tx_next      = tx_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        start_now    = 1'b0;
        pop          = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (can_start) start_now = 1'b1;
            end
            S_START: begin
                if (timer_reg == '0) begin
                    state_next   = S_DATA;
                    timer_next   = div_lat_reg;
                    bit_cnt_next = '0;
                    tx_next      = shift_reg[0];
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            S_DATA: begin
                if (timer_reg == '0) begin
                    timer_next = div_lat_reg;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next  = S_STOP;
                        tx_next     = 1'b1;
                        second_next = 1'b0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        shift_next   = {1'b0, shift_reg[7:1]};
                        tx_next      = shift_reg[1];
                    end
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            S_STOP: begin
                if (timer_reg == '0) begin
                    if (s2_lat_reg && !second_reg) begin
                        second_next = 1'b1;
                        timer_next  = div_lat_reg;
                    end else begin
                        done_next = 1'b1;
                        if (can_start) begin
                            start_now = 1'b1;
                        end else begin
                            state_next = S_IDLE;
                            busy_next  = 1'b0;
                        end
                    end
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
                tx_next    = 1'b1;
                busy_next  = 1'b0;
            end
        endcase

        // Shared frame launch: pop a byte and freeze this frame's timing settings
        if (start_now) begin
            pop          = 1'b1;
            shift_next   = mem[rd_ptr_reg];
            div_lat_next = div;
            timer_next   = div;
            s2_lat_next  = stop2;
            tx_next      = 1'b0;
            busy_next    = 1'b1;
            state_next   = S_START;
        end
    end

    assign level = level_reg;
    assign ovf   = ovf_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;
    assign tx    = tx_reg;

endmodule

// File: tb/tb_n5_uart_tx.sv
// tb_n5_uart_tx: self-checking bench for n5_uart_tx.
// Expected waveforms come from the frame rule: bit index = cycle / (div+1).
module tb_n5_uart_tx;

    localparam int DEPTH = 8;
    localparam int DIV_W = 16;

    logic                   wb_clk_i = 1'b0;
    logic                   wb_rst_i;
    logic                   en;
    logic [DIV_W-1:0]       div;
    logic                   stop2;
    logic [7:0]             wdata;
    logic                   wr;
    logic                   clr_ovf;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] level;
    logic                   ovf;
    logic                   busy;
    logic                   done;
    logic                   tx;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic       clr;
        int         lvl;
        logic       full;
        logic       empty;
        logic       ovf;
    } vec_t;

    vec_t       vecs [13];
    logic [7:0] model_q [$];

    n5_uart_tx #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .en       (en),
        .div      (div),
        .stop2    (stop2),
        .wdata    (wdata),
        .wr       (wr),
        .clr_ovf  (clr_ovf),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .ovf      (ovf),
        .busy     (busy),
        .done     (done),
        .tx       (tx)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called at the first cycle of a frame (tx just fell). Walks the whole frame,
    // then checks the done cycle. Mid-frame div/stop2 are scrambled to prove latching.
    task automatic expect_frame(input logic [7:0] b, input int d, input bit s2, input bit nxt,
                                input int nd, input bit ns2, input int drop_at,
                                input bit push_end, input logic [7:0] pb);
        int   per, len, idx, tx_err, busy_err, done_err;
        logic eb;
        per      = d + 1;
        len      = (s2 ? 11 : 10) * per;
        tx_err   = 0;
        busy_err = 0;
        done_err = 0;
        for (int i = 0; i < len; i++) begin
            idx = i / per;
            if (idx == 0)      eb = 1'b0;
            else if (idx <= 8) eb = b[idx-1];
            else               eb = 1'b1;
            if (tx !== eb)                tx_err++;
            if (busy !== 1'b1)            busy_err++;
            if (i > 0 && done !== 1'b0)   done_err++;
            if (i == 1) begin
                div   = DIV_W'($urandom);
                stop2 = 1'($urandom);
            end
            if (i == drop_at) en = 1'b0;
            if (i == len - 1) begin
                div   = DIV_W'(nd);
                stop2 = ns2;
                if (push_end) begin
                    wr    = 1'b1;
                    wdata = pb;
                end
            end
            tick();
            wr = 1'b0;
        end
        $display("frame byte=%02h div=%0d stop2=%0d cycles=%0d tx_err=%0d", b, d, s2, len, tx_err);
        check("frame_tx", tx_err, 0);
        check("frame_busy", busy_err, 0);
        check("frame_done_mid", done_err, 0);
        check("frame_done_end", done, 1);
        check("frame_end_tx", tx, nxt ? 0 : 1);
        check("frame_end_busy", busy, nxt ? 1 : 0);
    endtask

    // Watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        int         dq [9];
        bit         sq [9];
        int         w;

        wb_rst_i = 1'b1;
        en = 1'b0; div = '0; stop2 = 1'b0; wdata = '0; wr = 1'b0; clr_ovf = 1'b0;

        // Reset values
        tick(); tick();
        wb_rst_i = 1'b0;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);

        // Single byte 0x55, div=15
        div = 16'd15; stop2 = 1'b0; en = 1'b1;
        wr = 1'b1; wdata = 8'h55;
        tick();
        wr = 1'b0;
        check("push_level", level, 1);
        check("push_empty", empty, 0);
        check("push_tx_idle", tx, 1);
        tick();
        check("start_pop_level", level, 0);
        expect_frame(8'h55, 15, 1'b0, 1'b0, 15, 1'b0, -1, 1'b0, 8'h00);
        tick();
        check("done_one_cycle", done, 0);

        // Back-to-back "ABC"
        wr = 1'b1; wdata = 8'h41;
        tick();
        wdata = 8'h42;
        tick();
        wdata = 8'h43;
        expect_frame(8'h41, 15, 1'b0, 1'b1, 15, 1'b0, -1, 1'b0, 8'h00);
        expect_frame(8'h42, 15, 1'b0, 1'b1, 15, 1'b0, -1, 1'b0, 8'h00);
        expect_frame(8'h43, 15, 1'b0, 1'b0, 15, 1'b0, -1, 1'b0, 8'h00);

        // Overflow table with en=0
        en = 1'b0; div = 16'd1; stop2 = 1'b0;
        for (int k = 0; k < 8; k++)
            vecs[k] = '{1'b1, 8'(k), 1'b0, k + 1, (k == 7), 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 8'h08, 1'b0, 8, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 8, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 8'h09, 1'b1, 8, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 8, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 8'h0A, 1'b0, 8, 1'b1, 1'b0, 1'b1};
        for (int r = 0; r < 13; r++) begin
            wr = vecs[r].wr; wdata = vecs[r].d; clr_ovf = vecs[r].clr;
            tick();
            wr = 1'b0; clr_ovf = 1'b0;
            $display("vec %0d wr=%0b d=%02h clr=%0b level=%0d full=%0b ovf=%0b",
                     r, vecs[r].wr, vecs[r].d, vecs[r].clr, level, full, ovf);
            check($sformatf("vec%0d_level", r), level, vecs[r].lvl);
            check($sformatf("vec%0d_full", r), full, vecs[r].full);
            check($sformatf("vec%0d_empty", r), empty, vecs[r].empty);
            check($sformatf("vec%0d_ovf", r), ovf, vecs[r].ovf);
        end
        en = 1'b1;
        tick();
        for (int k = 0; k < 8; k++)
            expect_frame(8'(k), 1, 1'b0, k < 7, 1, 1'b0, -1, 1'b0, 8'h00);
        check("ovf_sticky", ovf, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_cleared", ovf, 0);

        // Randomized refills (cross the pointer wrap) against a queue model
        for (int round = 0; round < 3; round++) begin
            en = 1'b0;
            for (int k = 0; k < 8; k++) begin
                b = 8'($urandom);
                model_q.push_back(b);
                wr = 1'b1; wdata = b;
                tick();
            end
            wr = 1'b0;
            for (int k = 0; k < 9; k++) begin
                dq[k] = $urandom_range(0, 4);
                sq[k] = 1'($urandom_range(0, 1));
            end
            check("rand_fill_level", level, 8);
            div = DIV_W'(dq[0]); stop2 = sq[0]; en = 1'b1;
            w = 0;
            do begin
                tick();
                w++;
            end while (tx !== 1'b0 && w < 8);
            check("rand_start", tx, 0);
            for (int k = 0; k < 8; k++) begin
                b = model_q.pop_front();
                expect_frame(b, dq[k], sq[k], k < 7, dq[k+1], sq[k+1], -1, 1'b0, 8'h00);
            end
        end

        // Simultaneous push/pop, then reset mid-frame
        en = 1'b0; div = 16'd1; stop2 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            wr = 1'b1; wdata = 8'(8'h10 + k);
            tick();
        end
        wr = 1'b0;
        check("sim_fill_level", level, 8);
        check("sim_fill_full", full, 1);
        en = 1'b1; wr = 1'b1; wdata = 8'hEE;
        tick();
        wr = 1'b0;
        check("full_pop_level", level, 7);
        check("full_pop_ovf", ovf, 1);
        check("full_pop_full", full, 0);
        check("full_pop_tx", tx, 0);
        expect_frame(8'h10, 1, 1'b0, 1'b1, 1, 1'b0, -1, 1'b1, 8'hEF);
        check("push_pop_level", level, 7);
        repeat (6) tick();
        wb_rst_i = 1'b1;
        tick();
        wb_rst_i = 1'b0;
        check("midrst_tx", tx, 1);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_level", level, 0);
        check("midrst_empty", empty, 1);
        check("midrst_ovf", ovf, 0);
        repeat (3) tick();
        check("midrst_no_resume_tx", tx, 1);
        check("midrst_no_resume_busy", busy, 0);
        wr = 1'b1; wdata = 8'hA5;
        tick();
        wr = 1'b0;
        tick();
        expect_frame(8'hA5, 1, 1'b0, 1'b0, 1, 1'b0, -1, 1'b0, 8'h00);

        // en dropped during DATA with two stop bits, div=3 (44-cycle frame)
        en = 1'b0; div = 16'd3; stop2 = 1'b1;
        wr = 1'b1; wdata = 8'h3C;
        tick();
        wdata = 8'hC3;
        tick();
        wr = 1'b0;
        en = 1'b1;
        tick();
        expect_frame(8'h3C, 3, 1'b1, 1'b0, 3, 1'b1, 12, 1'b0, 8'h00);
        check("endrop_level", level, 1);
        repeat (5) tick();
        check("endrop_hold_tx", tx, 1);
        check("endrop_hold_busy", busy, 0);
        check("endrop_hold_level", level, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
